// File: rtl/pad_input_conditioner_if.sv
// Pad-side signal bundle: raw inputs in, conditioned levels, edge pulses and the
// debounce prescaler strobe out.
`timescale 1ns/1ps

interface pad_input_conditioner_if #(
  parameter int NUM_INPUTS = 68
);
  logic [NUM_INPUTS-1:0] input_in;
  logic [NUM_INPUTS-1:0] input_sync;
  logic [NUM_INPUTS-1:0] input_stable;
  logic [NUM_INPUTS-1:0] input_rise;
  logic [NUM_INPUTS-1:0] input_fall;
  logic                  tick;

  modport master (
    output input_in,
    input  input_sync,
    input  input_stable,
    input  input_rise,
    input  input_fall,
    input  tick
  );

  modport slave (
    input  input_in,
    output input_sync,
    output input_stable,
    output input_rise,
    output input_fall,
    output tick
  );
endinterface

// File: rtl/pad_input_conditioner.sv
// First stage after the pad ring: reset synchronizer, input synchronizers,
// tick-sampled debouncers and registered rise/fall pulse generation.
`timescale 1ns/1ps

module pad_input_conditioner #(
  parameter int NUM_INPUTS     = 68,
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    rst_n_sync,
  pad_input_conditioner_if.slave  pads
);

  localparam int             PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_TC = PW'(TICK_DIV - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [NUM_INPUTS-1:0]  in_sync_q [SYNC_STAGES];
  logic [NUM_INPUTS-1:0]  sync_w;
  logic [PW-1:0]          pre_cnt_q;
  logic                   tick_w;
  logic [NUM_INPUTS-1:0]  stable_q;
  logic [NUM_INPUTS-1:0]  stable_nxt;
  logic [NUM_INPUTS-1:0]  stable_d_q;
  logic [NUM_INPUTS-1:0]  rise_q;
  logic [NUM_INPUTS-1:0]  fall_q;

  // Reset asserts straight from the pad, releases only after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        in_sync_q[s] <= '0;
      end
    end else begin
      in_sync_q[0] <= pads.input_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        in_sync_q[s] <= in_sync_q[s-1];
      end
    end
  end

  assign sync_w = in_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      pre_cnt_q <= '0;
    end else if (pre_cnt_q == PRE_TC) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + 1'b1;
    end
  end

  // Gated by reset so a TICK_DIV of 1 does not strobe while the core is held.
  assign tick_w = rst_n_sync && (pre_cnt_q == PRE_TC);

  generate
    if (DEBOUNCE_TICKS == 0) begin : g_bypass
      assign stable_nxt = sync_w;
    end else begin : g_db
      localparam int            CW    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
      localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_TICKS - 1);

      logic [CW-1:0] cnt_q   [NUM_INPUTS];
      logic [CW-1:0] cnt_nxt [NUM_INPUTS];

      // Any return to the stable level clears progress, so short glitches never accumulate.
      always_comb begin
        stable_nxt = stable_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          cnt_nxt[i] = cnt_q[i];
          if (sync_w[i] == stable_q[i]) begin
            cnt_nxt[i] = '0;
          end else if (tick_w && (cnt_q[i] == DB_TC)) begin
            stable_nxt[i] = sync_w[i];
            cnt_nxt[i]    = '0;
          end else if (tick_w) begin
            cnt_nxt[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_q[i] <= cnt_nxt[i];
          end
        end
      end
    end
  endgenerate

  // Pulses come one cycle after the stable level changes; reset clears both
  // the level and its delayed copy so reset itself never produces an edge.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      stable_q   <= '0;
      stable_d_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
    end else begin
      stable_q   <= stable_nxt;
      stable_d_q <= stable_q;
      rise_q     <= stable_q & ~stable_d_q;
      fall_q     <= ~stable_q & stable_d_q;
    end
  end

  assign pads.input_sync   = sync_w;
  assign pads.input_stable = stable_q;
  assign pads.input_rise   = rise_q;
  assign pads.input_fall   = fall_q;
  assign pads.tick         = tick_w;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner: debounced instance plus a bypass
// instance, with a pulse scoreboard per instance.
`timescale 1ns/1ps

module tb_pad_input_conditioner;
  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_sync_m;
  logic rst_n_sync_b;

  always #5 clk = ~clk;

  pad_input_conditioner_if #(.NUM_INPUTS(N)) m_if ();
  pad_input_conditioner_if #(.NUM_INPUTS(N)) b_if ();

  pad_input_conditioner #(
    .NUM_INPUTS(N), .SYNC_STAGES(2), .TICK_DIV(4), .DEBOUNCE_TICKS(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .rst_n_sync(rst_n_sync_m), .pads(m_if.slave)
  );

  pad_input_conditioner #(
    .NUM_INPUTS(N), .SYNC_STAGES(2), .TICK_DIV(1), .DEBOUNCE_TICKS(0)
  ) u_byp (
    .clk(clk), .rst_n(rst_n), .rst_n_sync(rst_n_sync_b), .pads(b_if.slave)
  );

  int  checks = 0;
  int  errors = 0;
  ev_t q_main[$];
  ev_t q_byp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every pulse seen must match the oldest expected event; extra pulses fail.
  always @(negedge clk) begin
    if ((m_if.input_rise | m_if.input_fall) != '0) begin
      if (q_main.size() == 0) chk("main_unexpected_pulse", {m_if.input_rise, m_if.input_fall}, 32'h0);
      else chk("main_pulse", {m_if.input_rise, m_if.input_fall}, q_main.pop_front());
    end
    if ((b_if.input_rise | b_if.input_fall) != '0) begin
      if (q_byp.size() == 0) chk("byp_unexpected_pulse", {b_if.input_rise, b_if.input_fall}, 32'h0);
      else chk("byp_pulse", {b_if.input_rise, b_if.input_fall}, q_byp.pop_front());
    end
  end

  initial begin
    logic       found;
    int         k;
    logic       cur;
    logic [3:0] hist;

    rst_n         = 1'b1;
    m_if.input_in = '0;
    b_if.input_in = '0;

    // Reset assertion between edges, no clock needed
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_low", rst_n_sync_m, 0);
    chk("rst_outs_zero", {m_if.input_sync, m_if.input_stable, m_if.input_rise, m_if.input_fall, m_if.tick}, 0);
    step();
    step();
    chk("rst_held", rst_n_sync_m, 0);
    chk("byp_tick_in_rst", b_if.tick, 0);

    // Release: high on the 2nd rising edge
    rst_n = 1'b1;
    step();
    chk("rel_edge1", rst_n_sync_m, 0);
    chk("rel_edge1_tick", m_if.tick, 0);
    step();
    chk("rel_edge2", rst_n_sync_m, 1);
    chk("byp_rel_edge2", rst_n_sync_b, 1);
    chk("byp_tick_div1", b_if.tick, 1);

    // Prescaler period of 4 starting from count 0
    for (int j = 0; j < 8; j++) begin
      chk("tick_phase", m_if.tick, ((j % 4) == 3) ? 1 : 0);
      step();
    end

    // Bypass instance: stable is input_in delayed 3 samples, pulses per transition
    hist = '0;
    for (int j = 0; j < 20; j++) begin
      if ((j % 2 == 0) && (j < 16)) begin
        b_if.input_in[0] = ~b_if.input_in[0];
        if (b_if.input_in[0]) q_byp.push_back(ev_t'{rise: 4'b0001, fall: 4'b0000});
        else                  q_byp.push_back(ev_t'{rise: 4'b0000, fall: 4'b0001});
      end
      cur = b_if.input_in[0];
      step();
      hist = {hist[2:0], cur};
      chk("byp_sync", b_if.input_sync[0], hist[1]);
      chk("byp_stable", b_if.input_stable[0], hist[2]);
    end
    chk("byp_tick_steady", b_if.tick, 1);

    // Clean press on bit 0
    m_if.input_in[0] = 1'b1;
    q_main.push_back(ev_t'{rise: 4'b0001, fall: 4'b0000});
    step();
    chk("press_sync_lat1", m_if.input_sync[0], 0);
    step();
    chk("press_sync_lat2", m_if.input_sync[0], 1);
    found = 1'b0;
    k = 0;
    while (!found && k < 16) begin
      step();
      k++;
      if (m_if.input_stable[0]) found = 1'b1;
    end
    chk("press_found", found, 1);
    chk("press_latency_9_12", ((k >= 9) && (k <= 12)) ? 1 : 0, 1);
    chk("press_rise_not_yet", {m_if.input_rise, m_if.input_fall}, 0);
    step();
    chk("press_rise", {m_if.input_rise, m_if.input_fall}, 8'b0001_0000);
    step();
    chk("press_rise_clear", {m_if.input_rise, m_if.input_fall}, 0);

    // Glitches on bit 1: three 6-cycle highs must never accumulate into an update
    repeat (3) begin
      m_if.input_in[1] = 1'b1;
      repeat (6) step();
      m_if.input_in[1] = 1'b0;
      repeat (3) step();
    end
    repeat (16) step();
    chk("glitch_stable", m_if.input_stable[1], 0);

    // Bring bit 3 high so it can fall alongside bit 2 rising
    m_if.input_in[3] = 1'b1;
    q_main.push_back(ev_t'{rise: 4'b1000, fall: 4'b0000});
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      step();
      k++;
      if (m_if.input_stable[3]) found = 1'b1;
    end
    chk("bit3_high_found", found, 1);
    repeat (4) step();

    m_if.input_in[2] = 1'b1;
    m_if.input_in[3] = 1'b0;
    q_main.push_back(ev_t'{rise: 4'b0100, fall: 4'b1000});
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      step();
      k++;
      if (m_if.input_stable[2]) found = 1'b1;
    end
    chk("simul_found", found, 1);
    chk("simul_stable", m_if.input_stable, 4'b0101);
    step();
    chk("simul_pulse", {m_if.input_rise, m_if.input_fall}, 8'b0100_1000);

    // Return everything low
    m_if.input_in = '0;
    q_main.push_back(ev_t'{rise: 4'b0000, fall: 4'b0101});
    repeat (20) step();
    chk("settle_stable", m_if.input_stable, 0);

    // Reset during debounce progress
    m_if.input_in[0] = 1'b1;
    repeat (2) step();
    chk("mid_sync_pre", m_if.input_sync[0], 1);
    repeat (8) step();
    chk("mid_stable_pre", m_if.input_stable[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_async", rst_n_sync_m, 0);
    chk("mid_outs_zero", {m_if.input_sync, m_if.input_stable, m_if.input_rise, m_if.input_fall, m_if.tick}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_edge1", rst_n_sync_m, 0);
    step();
    chk("mid_rel_edge2", rst_n_sync_m, 1);
    q_main.push_back(ev_t'{rise: 4'b0001, fall: 4'b0000});
    step();
    chk("mid_sync_lat1", m_if.input_sync[0], 0);
    step();
    chk("mid_sync_lat2", m_if.input_sync[0], 1);
    found = 1'b0;
    k = 0;
    while (!found && k < 16) begin
      step();
      k++;
      if (m_if.input_stable[0]) found = 1'b1;
    end
    chk("mid_found", found, 1);
    chk("mid_latency_9_12", ((k >= 9) && (k <= 12)) ? 1 : 0, 1);
    repeat (8) step();

    chk("q_main_empty", q_main.size(), 0);
    chk("q_byp_empty", q_byp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
